path_replay: RTL and testbench

PATH_REPLAY -- requirements
Module: path_replay

---
 rtl/path_replay.sv | 215 +++++++++++++++++++++
 tb/tb_path_replay.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_replay.sv
// rtl/path_replay.sv - collects a solver path burst into a LIFO and replays it start-to-target
//
// Purpose:
//   A maze solver emits its path target-first as a burst of in_valid cycles.
//   The block stacks the coordinates (up to 128), checks that consecutive
//   entries are unit steps and that the path runs (13,13) -> (1,1), then
//   replays the stack in reverse (start-to-target) over a valid/ready port
//   and pulses done with the burst summary.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid          solver coordinate strobe, a run of 1s is one burst
//   maze_not_valid    solver "no path" verdict, sampled with in_valid
//   in_x, in_y        path coordinate (4 bits each)
//   out_ready         downstream accepts the presented coordinate
//   out_valid         replay coordinate valid
//   out_x, out_y      replayed coordinate
//   out_last          final replayed coordinate
//   done              one-cycle pulse ending every burst
//   path_len          stored entry count, valid with done and held after
//   path_err          path check failed, valid with done and held after
//   no_path           solver reported no path, valid with done and held after
//   busy              high outside IDLE

module path_replay (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       maze_not_valid,
   input  logic [3:0] in_x,
   input  logic [3:0] in_y,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_x,
   output logic [3:0] out_y,
   output logic       out_last,
   output logic       done,
   output logic [7:0] path_len,
   output logic       path_err,
   output logic       no_path,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_REPLAY  = 2'd2,
      S_REPORT  = 2'd3
   } state_t;

   localparam logic [7:0] TARGET_XY = 8'hDD;   // (13,13), first entry of a legal burst
   localparam logic [7:0] START_XY  = 8'h11;   // (1,1), last entry of a legal burst
   localparam logic [7:0] DEPTH     = 8'd128;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [6:0] rd_idx_q, rd_idx_d;
   logic       err_q, err_d;
   logic [7:0] first_q, first_d;       // entry 0, kept for the end-of-burst check
   logic [7:0] prev_q, prev_d;         // most recently stored entry
   logic [7:0] path_len_q, path_len_d;
   logic       path_err_q, path_err_d;
   logic       no_path_q, no_path_d;

   logic [7:0] mem [0:127];
   logic       wr_en;
   logic [6:0] wr_idx;
   logic [7:0] wr_data;
   logic [7:0] rd_data;

   // True when a and b are exactly one grid step apart (|dx|+|dy| == 1).
   function automatic logic is_step(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] dx;
      logic [3:0] dy;
      logic [4:0] sum;
      dx  = (a[7:4] >= b[7:4]) ? (a[7:4] - b[7:4]) : (b[7:4] - a[7:4]);
      dy  = (a[3:0] >= b[3:0]) ? (a[3:0] - b[3:0]) : (b[3:0] - a[3:0]);
      sum = {1'b0, dx} + {1'b0, dy};
      return (sum == 5'd1);
   endfunction

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_idx_d   = rd_idx_q;
      err_d      = err_q;
      first_d    = first_q;
      prev_d     = prev_q;
      path_len_d = path_len_q;
      path_err_d = path_err_q;
      no_path_d  = no_path_q;
      wr_en      = 1'b0;
      wr_idx     = count_q[6:0];
      wr_data    = {in_x, in_y};

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (maze_not_valid) begin
                  path_len_d = 8'd0;
                  path_err_d = 1'b0;
                  no_path_d  = 1'b1;
                  state_d    = S_REPORT;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = 7'd0;
                  count_d = 8'd1;
                  first_d = wr_data;
                  prev_d  = wr_data;
                  err_d   = 1'b0;
                  state_d = S_COLLECT;
               end
            end
         end

         S_COLLECT: begin
            if (in_valid) begin
               if (maze_not_valid) begin
                  err_d = 1'b1;
               end
               if (count_q == DEPTH) begin
                  // Stack full: entry dropped, count saturates.
                  err_d = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + 8'd1;
                  prev_d  = wr_data;
                  if (!is_step(wr_data, prev_q)) begin
                     err_d = 1'b1;
                  end
               end
            end else begin
               if (first_q != TARGET_XY || prev_q != START_XY) begin
                  err_d = 1'b1;
               end
               // count is 1..128 here; the 7-bit truncation maps 128 to top index 127.
               rd_idx_d = 7'(count_q - 8'd1);
               state_d  = S_REPLAY;
            end
         end

         S_REPLAY: begin
            if (out_ready) begin
               if (rd_idx_q == 7'd0) begin
                  path_len_d = count_q;
                  path_err_d = err_q;
                  no_path_d  = 1'b0;
                  state_d    = S_REPORT;
               end else begin
                  rd_idx_d = rd_idx_q - 7'd1;
               end
            end
         end

         S_REPORT: begin
            count_d  = 8'd0;
            err_d    = 1'b0;
            rd_idx_d = 7'd0;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= 8'd0;
         rd_idx_q   <= 7'd0;
         err_q      <= 1'b0;
         first_q    <= 8'd0;
         prev_q     <= 8'd0;
         path_len_q <= 8'd0;
         path_err_q <= 1'b0;
         no_path_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_idx_q   <= rd_idx_d;
         err_q      <= err_d;
         first_q    <= first_d;
         prev_q     <= prev_d;
         path_len_q <= path_len_d;
         path_err_q <= path_err_d;
         no_path_q  <= no_path_d;
      end
   end

   // Path storage carries no reset; only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx_q];

   // Replay outputs are decoded from the registered state and index, so they
   // are stable across stalls and drop to zero as soon as reset asserts.
   always_comb begin
      out_valid = (state_q == S_REPLAY);
      out_x     = out_valid ? rd_data[7:4] : 4'd0;
      out_y     = out_valid ? rd_data[3:0] : 4'd0;
      out_last  = out_valid && (rd_idx_q == 7'd0);
      done      = (state_q == S_REPORT);
      busy      = (state_q != S_IDLE);
      path_len  = path_len_q;
      path_err  = path_err_q;
      no_path   = no_path_q;
   end

endmodule

// File: tb/tb_path_replay.sv
// tb/tb_path_replay.sv - randomized self-checking bench for path_replay

module tb_path_replay;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       maze_not_valid = 1'b0;
   logic [3:0] in_x = 4'd0;
   logic [3:0] in_y = 4'd0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [3:0] out_x;
   logic [3:0] out_y;
   logic       out_last;
   logic       done;
   logic [7:0] path_len;
   logic       path_err;
   logic       no_path;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   // Burst under test: {maze_not_valid, x, y}
   logic [8:0] in_q[$];
   // Expected and observed replay words: {last, x, y}
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   logic [7:0] exp_len;
   logic       exp_err;
   logic       exp_np;

   logic [7:0] got_len;
   logic       got_err;
   logic       got_np;
   logic       busy_at_done;
   logic       idle_after;
   logic [7:0] len_after;
   int first_valid_k, last_xfer_k, done_k, done_cnt, stall_viol;

   path_replay dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .maze_not_valid(maze_not_valid),
      .in_x(in_x), .in_y(in_y), .out_ready(out_ready), .out_valid(out_valid),
      .out_x(out_x), .out_y(out_y), .out_last(out_last), .done(done),
      .path_len(path_len), .path_err(path_err), .no_path(no_path), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: what the burst should yield, derived from the path rules.
   task automatic model();
      int n, s, dx, dy;
      exp_q.delete();
      exp_len = 8'd0;
      exp_err = 1'b0;
      exp_np  = 1'b0;
      n = in_q.size();
      if (in_q[0][8]) begin
         exp_np = 1'b1;
         return;
      end
      s = (n > 128) ? 128 : n;
      exp_len = 8'(s);
      if (n > 128) exp_err = 1'b1;
      for (int i = 1; i < n; i++) if (in_q[i][8]) exp_err = 1'b1;
      for (int i = 1; i < s; i++) begin
         dx = int'(in_q[i][7:4]) - int'(in_q[i-1][7:4]);
         dy = int'(in_q[i][3:0]) - int'(in_q[i-1][3:0]);
         if (dx < 0) dx = -dx;
         if (dy < 0) dy = -dy;
         if (dx + dy != 1) exp_err = 1'b1;
      end
      if (in_q[0][7:0] != 8'hDD || in_q[s-1][7:0] != 8'h11) exp_err = 1'b1;
      for (int i = s - 1; i >= 0; i--) exp_q.push_back({(i == 0), in_q[i][7:0]});
   endtask

   task automatic build_legal();
      in_q.delete();
      for (int y = 13; y >= 1; y--) in_q.push_back({1'b0, 4'd13, 4'(y)});
      for (int x = 12; x >= 1; x--) in_q.push_back({1'b0, 4'(x), 4'd1});
   endtask

   task automatic drive_burst();
      foreach (in_q[i]) begin
         in_valid = 1'b1;
         maze_not_valid = in_q[i][8];
         in_x = in_q[i][7:4];
         in_y = in_q[i][3:0];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      maze_not_valid = 1'b0;
   endtask

   // Watches the replay port after a burst; k counts cycles after the last in_valid cycle.
   task automatic observe(input int mode, input bit noise, input int max_k);
      logic [8:0] prev_word;
      bit stalled;
      got_q.delete();
      first_valid_k = -1; last_xfer_k = -1; done_k = -1; done_cnt = 0; stall_viol = 0;
      stalled = 0; prev_word = 9'd0; got_len = 8'd0; got_err = 1'b0; got_np = 1'b0;
      busy_at_done = 1'b0;
      for (int k = 0; k < max_k; k++) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (noise && k >= 1) begin
            in_valid = 1'($urandom_range(0, 1));
            maze_not_valid = 1'($urandom_range(0, 1));
            in_x = 4'($urandom);
            in_y = 4'($urandom);
         end
         if (stalled && (out_valid !== 1'b1 || {out_last, out_x, out_y} !== prev_word))
            stall_viol++;
         stalled = 0;
         if (out_valid === 1'b1) begin
            if (first_valid_k < 0) first_valid_k = k;
            prev_word = {out_last, out_x, out_y};
            if (out_ready) begin
               got_q.push_back(prev_word);
               last_xfer_k = k;
            end else begin
               stalled = 1;
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_k = k;
            got_len = path_len;
            got_err = path_err;
            got_np = no_path;
            busy_at_done = busy;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      maze_not_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      idle_after = !busy && !out_valid && !done;
      len_after = path_len;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, out_x, out_y, out_last, done} !== 11'd0) begin
         tests_failed++;
         $display("FAIL reset_replay_outputs got=%b want=0", {out_valid, out_x, out_y, out_last, done});
      end
      tests_run++;
      if ({path_len, path_err, no_path, busy} !== 11'd0) begin
         tests_failed++;
         $display("FAIL reset_status got=%h want=0", {path_len, path_err, no_path, busy});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_legal();
      build_legal();
      model();
      drive_burst();
      observe(0, 1'b0, 100);
      tests_run++;
      if (got_q.size() !== 25) begin
         tests_failed++;
         $display("FAIL legal_xfers got=%0d want=25", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         tests_run++;
         if (got_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL legal_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
         end
      end
      tests_run++;
      if ({done_cnt == 1, got_len, got_err, got_np, busy_at_done} !== {1'b1, 8'd25, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL legal_done cnt=%0d len=%0d err=%b np=%b busy=%b want 1/25/0/0/1",
                  done_cnt, got_len, got_err, got_np, busy_at_done);
      end
      tests_run++;
      if (first_valid_k !== 1 || done_k !== last_xfer_k + 1) begin
         tests_failed++;
         $display("FAIL legal_latency first_valid=%0d want=1 done=%0d want=%0d",
                  first_valid_k, done_k, last_xfer_k + 1);
      end
      tests_run++;
      if (idle_after !== 1'b1 || len_after !== 8'd25) begin
         tests_failed++;
         $display("FAIL legal_hold idle=%b len=%0d want idle=1 len=25", idle_after, len_after);
      end
   endtask

   task automatic test_no_path();
      in_q.delete();
      in_q.push_back({1'b1, 4'd3, 4'd7});
      drive_burst();
      observe(0, 1'b0, 10);
      tests_run++;
      if (done_k !== 0 || first_valid_k !== -1 || got_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL no_path_timing done_k=%0d first_valid=%0d xfers=%0d want 0/-1/0",
                  done_k, first_valid_k, got_q.size());
      end
      tests_run++;
      if ({got_len, got_err, got_np} !== {8'd0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL no_path_status len=%0d err=%b np=%b want 0/0/1", got_len, got_err, got_np);
      end
   endtask

   task automatic test_jump();
      build_legal();
      in_q.delete(1);   // drop (13,12): (13,13) -> (13,11)
      model();
      drive_burst();
      observe(0, 1'b0, 100);
      tests_run++;
      if (got_q != exp_q || got_q.size() != 24) begin
         tests_failed++;
         $display("FAIL jump_replay xfers=%0d want=24 (or content differs)", got_q.size());
      end
      tests_run++;
      if ({done_cnt == 1, got_len, got_err, got_np} !== {1'b1, 8'd24, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL jump_status cnt=%0d len=%0d err=%b np=%b want 1/24/1/0",
                  done_cnt, got_len, got_err, got_np);
      end
   endtask

   task automatic test_stall();
      in_q.delete();
      in_q.push_back({1'b0, 4'd13, 4'd13});
      in_q.push_back({1'b0, 4'd13, 4'd12});
      in_q.push_back({1'b0, 4'd12, 4'd12});
      in_q.push_back({1'b0, 4'd12, 4'd11});
      in_q.push_back({1'b0, 4'd11, 4'd11});
      model();
      drive_burst();
      observe(1, 1'b0, 60);
      tests_run++;
      if (stall_viol !== 0) begin
         tests_failed++;
         $display("FAIL stall_stable violations=%0d want=0", stall_viol);
      end
      tests_run++;
      if (got_q != exp_q || got_q.size() != 5) begin
         tests_failed++;
         $display("FAIL stall_order xfers=%0d want=5 (or content differs)", got_q.size());
      end
      tests_run++;
      if ({done_cnt == 1, got_len, got_err} !== {1'b1, exp_len, exp_err}) begin
         tests_failed++;
         $display("FAIL stall_status cnt=%0d len=%0d err=%b want 1/%0d/%b",
                  done_cnt, got_len, got_err, exp_len, exp_err);
      end
   endtask

   task automatic test_overflow();
      in_q.delete();
      for (int i = 0; i < 130; i++) in_q.push_back({1'b0, 4'($urandom), 4'($urandom)});
      model();
      drive_burst();
      observe(0, 1'b0, 200);
      tests_run++;
      if (got_q.size() !== 128 || got_q != exp_q) begin
         tests_failed++;
         $display("FAIL overflow_replay xfers=%0d want=128 (or content differs)", got_q.size());
      end
      tests_run++;
      if ({done_cnt == 1, got_len, got_err} !== {1'b1, 8'd128, 1'b1}) begin
         tests_failed++;
         $display("FAIL overflow_status cnt=%0d len=%0d err=%b want 1/128/1", done_cnt, got_len, got_err);
      end
   endtask

   task automatic test_reset_mid();
      int xfers;
      bit hit;
      int done_seen;
      build_legal();
      drive_burst();
      out_ready = 1'b1;
      xfers = 0;
      hit = 0;
      for (int k = 0; k < 60; k++) begin
         if (out_valid === 1'b1 && xfers == 2) begin
            rst_n = 1'b0;
            #1;
            hit = 1;
            break;
         end
         if (out_valid === 1'b1) xfers++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (hit !== 1'b1 || {out_valid, out_x, out_y, out_last, done, path_len, path_err, no_path, busy} !== 22'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs reached=%b got=%h want=0", hit,
                  {out_valid, out_x, out_y, out_last, done, path_len, path_err, no_path, busy});
      end
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || out_valid === 1'b1) done_seen++;
      end
      rst_n = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
      tests_run++;
      if (done_seen !== 0) begin
         tests_failed++;
         $display("FAIL reset_mid_no_done activity=%0d want=0", done_seen);
      end
      build_legal();
      model();
      drive_burst();
      observe(0, 1'b0, 100);
      tests_run++;
      if (got_q != exp_q || {done_cnt == 1, got_len, got_err} !== {1'b1, 8'd25, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_mid_recover xfers=%0d len=%0d err=%b want 25/25/0", got_q.size(), got_len, got_err);
      end
   endtask

   task automatic test_random();
      int n, x, y, d;
      for (int b = 0; b < 8; b++) begin
         in_q.delete();
         n = $urandom_range(1, 40);
         x = 13;
         y = 13;
         in_q.push_back({1'b0, 4'd13, 4'd13});
         for (int i = 1; i < n; i++) begin
            d = $urandom_range(0, 3);
            if (d == 0) x = (x > 0) ? x - 1 : x + 1;
            if (d == 1) y = (y > 0) ? y - 1 : y + 1;
            if (d == 2) x = (x < 15) ? x + 1 : x - 1;
            if (d == 3) y = (y < 15) ? y + 1 : y - 1;
            if ($urandom_range(0, 9) == 0) x = (x < 14) ? x + 2 : x - 2;
            if (i == n - 1 && $urandom_range(0, 1) == 1) begin
               x = 1;
               y = 1;
            end
            in_q.push_back({($urandom_range(0, 14) == 0), 4'(x), 4'(y)});
         end
         model();
         drive_burst();
         observe(2, 1'b1, 8 * n + 40);
         tests_run++;
         if (got_q != exp_q || stall_viol != 0) begin
            tests_failed++;
            $display("FAIL random[%0d]_replay xfers=%0d want=%0d stall_violations=%0d",
                     b, got_q.size(), exp_q.size(), stall_viol);
         end
         tests_run++;
         if ({done_cnt == 1, got_len, got_err, got_np} !== {1'b1, exp_len, exp_err, exp_np}) begin
            tests_failed++;
            $display("FAIL random[%0d]_status cnt=%0d len=%0d err=%b np=%b want 1/%0d/%b/%b",
                     b, done_cnt, got_len, got_err, got_np, exp_len, exp_err, exp_np);
         end
         tests_run++;
         if (first_valid_k !== 1 || done_k !== last_xfer_k + 1 || idle_after !== 1'b1) begin
            tests_failed++;
            $display("FAIL random[%0d]_timing first_valid=%0d want=1 done=%0d want=%0d idle=%b",
                     b, first_valid_k, done_k, last_xfer_k + 1, idle_after);
         end
      end
   endtask

   initial begin
      test_reset();
      test_legal();
      test_no_path();
      test_jump();
      test_stall();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
